// File: rtl/bpred_btb_if.sv
// Fetch/resolve-side bundle for the branch target buffer: lookup, resolved-branch update, flush and stats.
// Purely a wire bundle; there is no handshake or backpressure, and every signal is sampled every cycle.
interface bpred_btb_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_pred_taken_i;
    logic [ADDR_W-1:0] upd_pred_target_i;
    logic              flush_i;
    logic              mispredict_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic [CNT_W-1:0]  branch_cnt_o;
    logic [CNT_W-1:0]  mispred_cnt_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i, flush_i,
        input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i, flush_i,
        output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped tagged BTB with saturating direction counters and mispredict/branch counters.
// Lookup and mispredict are combinational; table and counters update on the next edge. There is no backpressure.
module bpred_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bpred_btb_if.slave    bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("bpred_btb: ENTRIES must be a power of 2 and at least 2");
    end
    if (CTR_W < 1) begin : g_bad_ctr
        $error("bpred_btb: CTR_W must be at least 1");
    end

    logic [ENTRIES-1:0] valid_q;
    logic [CTR_W-1:0]   ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [CNT_W-1:0]   branch_cnt_q;
    logic [CNT_W-1:0]   mispred_cnt_q;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] uidx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] utag;
    logic             hit;
    logic             uhit;
    logic             mispredict;
    logic             unused_pc_lsbs;

    assign idx  = bus.pc_i[IDX_W+1:2];
    assign tag  = bus.pc_i[ADDR_W-1:IDX_W+2];
    assign uidx = bus.upd_pc_i[IDX_W+1:2];
    assign utag = bus.upd_pc_i[ADDR_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^{bus.pc_i[1:0], bus.upd_pc_i[1:0]};

    // Reads see the table state before this cycle's update lands.
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    assign bus.pred_taken_o  = hit && ctr_q[idx][CTR_W-1];
    assign bus.pred_target_o = bus.pred_taken_o ? tgt_q[idx] : bus.pc_i + ADDR_W'(4);

    assign mispredict = bus.upd_valid_i &&
                        ((bus.upd_taken_i != bus.upd_pred_taken_i) ||
                         (bus.upd_taken_i && (bus.upd_target_i != bus.upd_pred_target_i)));
    assign bus.mispredict_o  = mispredict;
    assign bus.redirect_pc_o = bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + ADDR_W'(4);

    assign bus.branch_cnt_o  = branch_cnt_q;
    assign bus.mispred_cnt_o = mispred_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
        end else if (bus.flush_i) begin
            valid_q <= '0;
        end else if (bus.upd_valid_i) begin
            if (uhit) begin
                if (bus.upd_taken_i) begin
                    if (ctr_q[uidx] != CTR_MAX) ctr_q[uidx] <= ctr_q[uidx] + 1'b1;
                end else begin
                    if (ctr_q[uidx] != '0) ctr_q[uidx] <= ctr_q[uidx] - 1'b1;
                end
            end else if (bus.upd_taken_i) begin
                valid_q[uidx] <= 1'b1;
                ctr_q[uidx]   <= CTR_WEAK;
            end
        end
    end

    // Tag/target payload is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !bus.flush_i && bus.upd_valid_i && bus.upd_taken_i) begin
            tag_q[uidx] <= utag;
            tgt_q[uidx] <= bus.upd_target_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (bus.upd_valid_i && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_bpred_btb.sv
// Bench for bpred_btb: scoreboarded lookups, updates, flush, async reset and counter saturation.
module tb_bpred_btb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bpred_btb_if #(.ADDR_W(32), .CNT_W(32)) ia ();
    bpred_btb_if #(.ADDR_W(32), .CNT_W(4))  ib ();

    bpred_btb #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ia));
    bpred_btb #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ib));

    localparam int F_PT = 0, F_PTGT = 1, F_MISP = 2, F_REDIR = 3;
    localparam int F_BCNT = 4, F_MCNT = 5, F_BCNT_B = 6, F_MCNT_B = 7;

    typedef struct {
        string       name;
        int          fld;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int bcnt_m = 0;
    int mcnt_m = 0;
    bit pend_b = 0;
    bit pend_m = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sel(input int f);
        case (f)
            F_PT:     return 64'(ia.pred_taken_o);
            F_PTGT:   return 64'(ia.pred_target_o);
            F_MISP:   return 64'(ia.mispredict_o);
            F_REDIR:  return 64'(ia.redirect_pc_o);
            F_BCNT:   return 64'(ia.branch_cnt_o);
            F_MCNT:   return 64'(ia.mispred_cnt_o);
            F_BCNT_B: return 64'(ib.branch_cnt_o);
            F_MCNT_B: return 64'(ib.mispred_cnt_o);
            default:  return '1;
        endcase
    endfunction

    task automatic push_exp(input string name, input int fld, input logic [63:0] val);
        exp_t e;
        e.name = name;
        e.fld  = fld;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, sel(e.fld), e.val);
        end
    endtask

    task automatic idle();
        ia.upd_valid_i = 0; ia.upd_pc_i = '0; ia.upd_taken_i = 0; ia.upd_target_i = '0;
        ia.upd_pred_taken_i = 0; ia.upd_pred_target_i = '0; ia.flush_i = 0;
        ib.upd_valid_i = 0; ib.upd_pc_i = '0; ib.upd_taken_i = 0; ib.upd_target_i = '0;
        ib.upd_pred_taken_i = 0; ib.upd_pred_target_i = '0; ib.flush_i = 0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        ia.pc_i = pc;
        push_exp("pred_taken", F_PT, 64'(pt));
        push_exp("pred_target", F_PTGT, 64'(tgt));
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic exp_misp, input logic [31:0] exp_redir);
        ia.upd_valid_i = 1; ia.upd_pc_i = pc; ia.upd_taken_i = tk; ia.upd_target_i = tgt;
        ia.upd_pred_taken_i = ptk; ia.upd_pred_target_i = ptgt;
        push_exp("mispredict", F_MISP, 64'(exp_misp));
        push_exp("redirect_pc", F_REDIR, 64'(exp_redir));
        pend_b = 1;
        pend_m = exp_misp;
    endtask

    // Counter expectations reflect updates retired before this cycle's edge.
    task automatic step();
        @(negedge clk);
        push_exp("branch_cnt", F_BCNT, 64'(bcnt_m));
        push_exp("mispred_cnt", F_MCNT, 64'(mcnt_m));
        drain();
        @(posedge clk);
        #1;
        if (pend_b) bcnt_m++;
        if (pend_m) mcnt_m++;
        pend_b = 0;
        pend_m = 0;
        idle();
    endtask

    initial begin
        idle();
        ia.pc_i = '0;
        ib.pc_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        lookup(32'h40, 0, 32'h44); step();
        // Same-cycle update is invisible to the lookup until the next cycle.
        lookup(32'h40, 0, 32'h44); upd(32'h40, 1, 32'h100, 0, 32'h44, 1, 32'h100); step();
        lookup(32'h40, 1, 32'h100); step();

        lookup(32'h80, 0, 32'h84); step();
        lookup(32'h80, 0, 32'h84); upd(32'h80, 1, 32'h200, 0, 32'h84, 1, 32'h200); step();
        lookup(32'h40, 0, 32'h44); step();
        lookup(32'h80, 1, 32'h200); step();

        upd(32'h40, 1, 32'h100, 0, 32'h44, 1, 32'h100); step();
        lookup(32'h40, 1, 32'h100); upd(32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h100); step();
        lookup(32'h40, 1, 32'h100); upd(32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h100); step();
        lookup(32'h40, 1, 32'h100); upd(32'h40, 0, 32'h0, 1, 32'h100, 1, 32'h44); step();
        lookup(32'h40, 1, 32'h100); upd(32'h40, 0, 32'h0, 1, 32'h100, 1, 32'h44); step();
        lookup(32'h40, 0, 32'h44); upd(32'h40, 0, 32'h0, 0, 32'h44, 0, 32'h44); step();
        lookup(32'h40, 0, 32'h44); upd(32'h40, 0, 32'h0, 0, 32'h44, 0, 32'h44); step();
        lookup(32'h40, 0, 32'h44); upd(32'h40, 1, 32'h100, 0, 32'h44, 1, 32'h100); step();
        lookup(32'h40, 0, 32'h44); upd(32'h40, 1, 32'h100, 0, 32'h44, 1, 32'h100); step();
        lookup(32'h40, 1, 32'h100); upd(32'h40, 1, 32'h140, 1, 32'h100, 1, 32'h140); step();
        lookup(32'h40, 1, 32'h140); step();

        lookup(32'h40, 1, 32'h140); upd(32'hC0, 1, 32'h300, 0, 32'hC4, 1, 32'h300);
        ia.flush_i = 1; step();
        lookup(32'h40, 0, 32'h44); step();
        lookup(32'hC0, 0, 32'hC4); step();

        lookup(32'hFFFF_FFFC, 0, 32'h0);
        upd(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 1, 32'h0); step();

        upd(32'h40, 1, 32'h100, 0, 32'h44, 1, 32'h100); step();
        lookup(32'h40, 1, 32'h100);
        #1 drain();
        #1 rst = 1;
        #1;
        push_exp("rst_pred_taken", F_PT, 64'd0);
        push_exp("rst_pred_target", F_PTGT, 64'h44);
        push_exp("rst_branch_cnt", F_BCNT, 64'd0);
        push_exp("rst_mispred_cnt", F_MCNT, 64'd0);
        drain();
        bcnt_m = 0;
        mcnt_m = 0;
        ia.upd_valid_i = 1; ia.upd_pc_i = 32'h80; ia.upd_taken_i = 1; ia.upd_target_i = 32'h200;
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        lookup(32'h80, 0, 32'h84); step();
        lookup(32'h40, 0, 32'h44); upd(32'h40, 1, 32'h100, 0, 32'h44, 1, 32'h100); step();
        lookup(32'h40, 1, 32'h100); step();

        ib.pc_i = 32'h40;
        for (int i = 1; i <= 18; i++) begin
            ib.upd_valid_i = 1; ib.upd_pc_i = 32'h40; ib.upd_taken_i = 1;
            ib.upd_target_i = 32'h100; ib.upd_pred_taken_i = 0; ib.upd_pred_target_i = 32'h44;
            @(posedge clk);
            #1 idle();
            push_exp("b_branch_cnt", F_BCNT_B, 64'((i > 15) ? 15 : i));
            push_exp("b_mispred_cnt", F_MCNT_B, 64'((i > 15) ? 15 : i));
            @(negedge clk);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
